// File: rtl/mac_acc_stage_if.sv
// Bundles the product-in and writeback handshake signals of the MAC accumulate stage.
// The master drives operands and wb_ready; the slave returns results and status.
interface mac_acc_stage_if #(
    parameter int unsigned WIDTH = 24
);
    logic [WIDTH-1:0] prod_in;
    logic [1:0]       op;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] wb_data;
    logic             wb_valid;
    logic             wb_ready;
    logic [WIDTH-1:0] acc_out;
    logic             ovf;
    logic             busy;

    modport master (
        output prod_in, op, in_valid, wb_ready,
        input  in_ready, wb_data, wb_valid, acc_out, ovf, busy
    );

    modport slave (
        input  prod_in, op, in_valid, wb_ready,
        output in_ready, wb_data, wb_valid, acc_out, ovf, busy
    );
endinterface

// File: rtl/mac_acc_stage.sv
// Multiply-accumulate stage: applies LOAD/ADD/SUB/CLEAR to the accumulator and
// queues each LOAD/ADD/SUB result in a 2-entry FIFO toward register writeback.
module mac_acc_stage #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    mac_acc_stage_if.slave bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;
    logic             wb_valid_q, wb_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;

    logic             accept, push, pop;
    logic [WIDTH-1:0] sum, diff;
    logic             acc_s, prod_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Every output comes straight from a flop, so in_ready never sees wb_ready.
    assign accept = bus.in_valid && in_ready_q;
    assign push   = accept && (bus.op != 2'b11);
    assign pop    = wb_valid_q && bus.wb_ready;

    assign bus.in_ready = in_ready_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.wb_valid = wb_valid_q;
    assign bus.acc_out  = acc_q;
    assign bus.ovf      = ovf_q;
    assign bus.busy     = busy_q;

    always_comb begin
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        sum      = acc_q + bus.prod_in;
        diff     = acc_q - bus.prod_in;
        acc_s    = acc_q[WIDTH-1];
        prod_s   = bus.prod_in[WIDTH-1];

        if (accept) begin
            case (bus.op)
                OP_LOAD: acc_d = bus.prod_in;
                OP_ADD: begin
                    acc_d = sum;
                    ovf_d = ovf_q | ((acc_s == prod_s) && (sum[WIDTH-1] != acc_s));
                end
                OP_SUB: begin
                    acc_d = diff;
                    ovf_d = ovf_q | ((acc_s != prod_s) && (diff[WIDTH-1] != acc_s));
                end
                default: begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                end
            endcase
        end

        // The queued value is the post-op accumulator, written on the same edge.
        if (push) begin
            mem_d[wr_ptr_q] = acc_d;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        wb_valid_d = (count_d != '0);
        busy_d     = (count_d != '0);
        in_ready_d = (count_d < CNT_W'(DEPTH));
        wb_data_d  = wb_valid_d ? mem_d[rd_ptr_d] : wb_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            mem_q      <= '{default: '0};
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            wb_data_q  <= '0;
            wb_valid_q <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            wb_data_q  <= wb_data_d;
            wb_valid_q <= wb_valid_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end
endmodule

// File: tb/tb_mac_acc_stage.sv
// Self-checking bench for mac_acc_stage: directed vector table, a hand-written
// in_ready/CLEAR sequence, then randomized traffic against a queue-based model.
module tb_mac_acc_stage;
    localparam int unsigned W = 24;
    localparam logic [1:0] LOAD = 2'b00, ADD = 2'b01, SUB = 2'b10, CLR = 2'b11;

    logic clk;
    logic rst_n;

    mac_acc_stage_if #(.WIDTH(W)) bus ();

    mac_acc_stage #(.WIDTH(W), .DEPTH(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain signed arithmetic and a queue of pending results.
    logic [W-1:0] mq[$];
    logic [W-1:0] m_acc;
    logic         m_ovf;
    logic [W-1:0] m_last;

    typedef struct {
        logic         rst;
        logic         iv;
        logic [1:0]   op;
        logic [W-1:0] prod;
        logic         wr;
        logic [W-1:0] e_acc;
        logic         e_ovf;
        logic         e_wbv;
        logic [W-1:0] e_wbd;
        logic         e_rdy;
        logic         e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic iv, input logic [1:0] op,
                                input logic [W-1:0] prod, input logic wr,
                                input logic [W-1:0] e_acc, input logic e_ovf,
                                input logic e_wbv, input logic [W-1:0] e_wbd,
                                input logic e_rdy, input logic e_busy);
        vec_t v;
        v.rst = rst; v.iv = iv; v.op = op; v.prod = prod; v.wr = wr;
        v.e_acc = e_acc; v.e_ovf = e_ovf; v.e_wbv = e_wbv; v.e_wbd = e_wbd;
        v.e_rdy = e_rdy; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic iv, input logic [1:0] op,
                              input logic [W-1:0] prod, input logic wr);
        longint s;
        bit     acc_ok;
        bit     do_pop;
        if (!rst) begin
            mq.delete();
            m_acc  = '0;
            m_ovf  = 1'b0;
            m_last = '0;
        end else begin
            acc_ok = iv && (mq.size() < 2);
            do_pop = (mq.size() > 0) && wr;
            if (do_pop) void'(mq.pop_front());
            if (acc_ok) begin
                case (op)
                    LOAD: begin m_acc = prod; mq.push_back(m_acc); end
                    ADD, SUB: begin
                        if (op == ADD) s = longint'($signed(m_acc)) + longint'($signed(prod));
                        else           s = longint'($signed(m_acc)) - longint'($signed(prod));
                        if (s > 64'sd8388607 || s < -64'sd8388608) m_ovf = 1'b1;
                        m_acc = W'(s);
                        mq.push_back(m_acc);
                    end
                    default: begin m_acc = '0; m_ovf = 1'b0; end
                endcase
            end
            if (mq.size() > 0) m_last = mq[0];
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " acc_out"},  32'(bus.acc_out),  32'(m_acc));
        check({tag, " ovf"},      32'(bus.ovf),      32'(m_ovf));
        check({tag, " wb_valid"}, 32'(bus.wb_valid), 32'(mq.size() > 0));
        check({tag, " in_ready"}, 32'(bus.in_ready), 32'(mq.size() < 2));
        check({tag, " busy"},     32'(bus.busy),     32'(mq.size() != 0));
        check({tag, " wb_data"},  32'(bus.wb_data),  32'(m_last));
    endtask

    task automatic do_cycle(input logic rst, input logic iv, input logic [1:0] op,
                            input logic [W-1:0] prod, input logic wr, input string tag);
        rst_n        = rst;
        bus.in_valid = iv;
        bus.op       = op;
        bus.prod_in  = prod;
        bus.wb_ready = wr;
        model_step(rst, iv, op, prod, wr);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.op       = LOAD;
        bus.prod_in  = '0;
        bus.wb_ready = 1'b0;
        m_acc = '0; m_ovf = 1'b0; m_last = '0;

        // rst iv op prod wr | acc ovf wbv wbd rdy busy
        vecs.push_back(mk(0, 1, ADD,  24'h000005, 1, 24'h000000, 0, 0, 24'h000000, 1, 0));
        vecs.push_back(mk(1, 1, LOAD, 24'h000010, 1, 24'h000010, 0, 1, 24'h000010, 1, 1));
        vecs.push_back(mk(1, 1, ADD,  24'h000005, 1, 24'h000015, 0, 1, 24'h000015, 1, 1));
        vecs.push_back(mk(1, 1, SUB,  24'h000003, 1, 24'h000012, 0, 1, 24'h000012, 1, 1));
        vecs.push_back(mk(1, 0, LOAD, 24'h000000, 1, 24'h000012, 0, 0, 24'h000012, 1, 0));
        vecs.push_back(mk(1, 1, LOAD, 24'h7FFFFF, 1, 24'h7FFFFF, 0, 1, 24'h7FFFFF, 1, 1));
        vecs.push_back(mk(1, 1, ADD,  24'h000001, 1, 24'h800000, 1, 1, 24'h800000, 1, 1));
        vecs.push_back(mk(1, 1, LOAD, 24'h000001, 1, 24'h000001, 1, 1, 24'h000001, 1, 1));
        vecs.push_back(mk(1, 1, CLR,  24'h000000, 1, 24'h000000, 0, 0, 24'h000001, 1, 0));
        vecs.push_back(mk(1, 0, LOAD, 24'h000000, 1, 24'h000000, 0, 0, 24'h000001, 1, 0));
        vecs.push_back(mk(1, 1, ADD,  24'h000001, 0, 24'h000001, 0, 1, 24'h000001, 1, 1));
        vecs.push_back(mk(1, 1, ADD,  24'h000001, 0, 24'h000002, 0, 1, 24'h000001, 0, 1));
        vecs.push_back(mk(1, 1, ADD,  24'h000001, 0, 24'h000002, 0, 1, 24'h000001, 0, 1));
        vecs.push_back(mk(1, 1, ADD,  24'h000001, 1, 24'h000002, 0, 1, 24'h000002, 1, 1));
        vecs.push_back(mk(1, 1, ADD,  24'h000001, 1, 24'h000003, 0, 1, 24'h000003, 1, 1));
        vecs.push_back(mk(1, 1, ADD,  24'h000001, 0, 24'h000004, 0, 1, 24'h000003, 0, 1));
        vecs.push_back(mk(0, 1, LOAD, 24'h000055, 0, 24'h000000, 0, 0, 24'h000000, 1, 0));
        vecs.push_back(mk(1, 0, LOAD, 24'h000000, 1, 24'h000000, 0, 0, 24'h000000, 1, 0));
        vecs.push_back(mk(1, 1, LOAD, 24'h800000, 1, 24'h800000, 0, 1, 24'h800000, 1, 1));
        vecs.push_back(mk(1, 1, SUB,  24'h000001, 1, 24'h7FFFFF, 1, 1, 24'h7FFFFF, 1, 1));
        vecs.push_back(mk(1, 1, CLR,  24'h000000, 0, 24'h000000, 0, 1, 24'h7FFFFF, 1, 1));
        vecs.push_back(mk(1, 0, LOAD, 24'h000000, 1, 24'h000000, 0, 0, 24'h7FFFFF, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            do_cycle(vecs[i].rst, vecs[i].iv, vecs[i].op, vecs[i].prod, vecs[i].wr, t);
            check({t, " tbl_acc"},  32'(bus.acc_out),  32'(vecs[i].e_acc));
            check({t, " tbl_ovf"},  32'(bus.ovf),      32'(vecs[i].e_ovf));
            check({t, " tbl_wbv"},  32'(bus.wb_valid), 32'(vecs[i].e_wbv));
            check({t, " tbl_rdy"},  32'(bus.in_ready), 32'(vecs[i].e_rdy));
            check({t, " tbl_busy"}, 32'(bus.busy),     32'(vecs[i].e_busy));
            if (vecs[i].e_wbv || !vecs[i].rst)
                check({t, " tbl_wbd"}, 32'(bus.wb_data), 32'(vecs[i].e_wbd));
        end

        // CLEAR offered while the FIFO is full must be refused like any op.
        do_cycle(1, 1, LOAD, 24'h000009, 0, "gate_fill0");
        do_cycle(1, 1, LOAD, 24'h00000A, 0, "gate_fill1");
        do_cycle(1, 1, CLR,  24'h000000, 0, "gate_clr");
        check("gate acc_kept", 32'(bus.acc_out), 32'h00000A);
        check("gate head",     32'(bus.wb_data), 32'h000009);
        do_cycle(1, 0, LOAD, 24'h000000, 1, "gate_drain0");
        check("gate second",   32'(bus.wb_data), 32'h00000A);
        do_cycle(1, 0, LOAD, 24'h000000, 1, "gate_drain1");
        check("gate empty",    32'(bus.wb_valid), 32'h0);

        // Randomized traffic with biased extremes to provoke overflow and full FIFO.
        for (int i = 0; i < 600; i++) begin
            logic [W-1:0] p;
            case ($urandom_range(0, 4))
                0:       p = 24'h7FFFFF;
                1:       p = 24'h800000;
                2:       p = W'($urandom_range(0, 15));
                default: p = W'($urandom);
            endcase
            do_cycle(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0),
                     2'($urandom_range(0, 3)), p, ($urandom_range(0, 2) != 0),
                     $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
